// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Boot-time writer for the instruction memory. Takes a byte stream (valid/ready):
//   a 16-bit little-endian word count followed by the image bytes. Bytes are packed
//   little-endian into 32-bit words, and each word is written at sequential word
//   addresses starting at BASE_ADDR. The core is held in reset until the load completes.
//
//   Optional feature: define INSTR_LOADER_CSUM_EN to expect one trailing checksum byte.
//   This byte must equal the XOR of all data bytes. A mismatch sets err and keeps
//   cpu_hold asserted.
//
// Parameters
//   ADDR_WIDTH  word-address width (memory depth = 2**ADDR_WIDTH words)
//   BASE_ADDR   first word address written
// Ports
//   clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   start      one-cycle pulse, starts a load (honoured only when idle or done)
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader can take a byte (transfer on in_valid & in_ready)
//   mem_we     instruction memory write strobe (one cycle per word)
//   mem_addr   word address of the write
//   mem_wdata  word to write
//   cpu_hold   1 = keep the core in reset
//   done       load complete (held until next start)
//   err        overflow / checksum error (held until next start)
module instr_mem_loader #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [23:0]             word_q, word_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    full_q, full_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    hold_q, hold_d;
`ifdef INSTR_LOADER_CSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic accept;
  logic load_end;

  // Ready is a pure function of registered state so the source can sample it safely.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StLen0, StLen1: in_ready = 1'b1;
      // Stays high through the write cycle; drops once every word has been taken.
      StData:         in_ready = (count_q != 16'd0);
`ifdef INSTR_LOADER_CSUM_EN
      StCsum:         in_ready = 1'b1;
`endif
      default:        in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    full_d     = full_q;
    err_d      = err_q;
    done_d     = done_q;
    hold_d     = hold_q;
    load_end   = 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    // Address advances the cycle after a write; the top word marks the memory full
    // instead of wrapping, so later words get dropped.
    if (mem_we_q) begin
      if (addr_q == AddrMax) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLen0;
          count_d    = 16'd0;
          byte_idx_d = 2'd0;
          addr_d     = BASE_ADDR;
          full_d     = 1'b0;
          err_d      = 1'b0;
          done_d     = 1'b0;
          hold_d     = 1'b1;
`ifdef INSTR_LOADER_CSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      StLen0: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = StLen1;
        end
      end

      StLen1: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if ({in_data, count_q[7:0]} == 16'd0) begin
            load_end = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (count_q == 16'd0) begin
          // Last word's write strobe (or drop) is happening this cycle.
          load_end = 1'b1;
        end else if (accept) begin
`ifdef INSTR_LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = in_data;
            2'd1:    word_d[15:8]  = in_data;
            2'd2:    word_d[23:16] = in_data;
            default: begin
              count_d = count_q - 16'd1;
              if (full_q) begin
                err_d = 1'b1;
              end else begin
                mem_we_d = 1'b1;
                wdata_d  = {in_data, word_q};
              end
            end
          endcase
        end
      end

`ifdef INSTR_LOADER_CSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = StDone;
          done_d  = 1'b1;
          if (in_data != csum_q) begin
            err_d  = 1'b1;
            hold_d = 1'b1;
          end else begin
            hold_d = err_q;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    if (load_end) begin
`ifdef INSTR_LOADER_CSUM_EN
      state_d = StCsum;
`else
      state_d = StDone;
      done_d  = 1'b1;
      hold_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      mem_we_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b1;
`ifdef INSTR_LOADER_CSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      full_q     <= full_d;
      err_q      <= err_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
`ifdef INSTR_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 256-word instance and a 4-word instance share one
// byte stream; each is scored against a reference built from the image bytes.
module tb_instr_mem_loader;

`ifdef INSTR_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  typedef wr_t wq_t[$];

  typedef struct packed {
    logic [79:0] stream;   // byte 0 in the top bits, stream order left to right
    logic [3:0]  nbytes;
    logic        gaps;
    logic [7:0]  exp_nwr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, mem_we, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        s_in_ready, s_mem_we, s_cpu_hold, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;

  int  checks = 0;
  int  errors = 0;
  wq_t wq, wq_s;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk       (clk),
    .Reset_n   (reset_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk       (clk),
    .Reset_n   (reset_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .mem_we    (s_mem_we),
    .mem_addr  (s_mem_addr),
    .mem_wdata (s_mem_wdata),
    .cpu_hold  (s_cpu_hold),
    .done      (s_done),
    .err       (s_err)
  );

  always @(negedge clk) begin
    if (mem_we)   wq.push_back({mem_addr, mem_wdata});
    if (s_mem_we) wq_s.push_back({6'd0, s_mem_addr, s_mem_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    got = 1'b0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check("handshake", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
  endtask

  // Expected behaviour computed directly from the image bytes and memory depth.
  task automatic check_model(input string tag, input bq_t img, input bit bad, input int depth,
                             input wq_t q, input logic [7:0] addr, input logic d,
                             input logic e, input logic h);
    int          cnt, nwr;
    bit          exp_err;
    logic [31:0] word;
    cnt     = int'({img[1], img[0]});
    nwr     = (cnt < depth) ? cnt : depth;
    exp_err = (cnt > depth) || (CsumEn && bad);
    check({tag, "_nwr"}, q.size(), nwr);
    for (int w = 0; w < nwr && w < q.size(); w++) begin
      word = {img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]};
      check({tag, "_waddr"}, 32'(q[w].addr), w);
      check({tag, "_wdata"}, q[w].data, word);
    end
    check({tag, "_addr"}, 32'(addr), (cnt < depth) ? cnt : depth - 1);
    check({tag, "_done"}, 32'(d), 32'd1);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_hold"}, 32'(h), (CsumEn && exp_err) ? 32'd1 : 32'd0);
  endtask

  task automatic run_load(input string tag, input bq_t img, input bit gaps, input bit bad,
                          input int start_at);
    logic [7:0] cs;
    cs = 8'd0;
    wq.delete();
    wq_s.delete();
    pulse_start();
    for (int i = 0; i < img.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(img[i], gaps);
      if (i >= 2) cs ^= img[i];
    end
    if (CsumEn) send_byte(bad ? (cs ^ 8'h5A) : cs, gaps);
    wait_done(tag);
    repeat (2) tick();
    check_model({tag, "_m"}, img, bad, 256, wq, mem_addr, done, err, cpu_hold);
    check_model({tag, "_s"}, img, bad, 4, wq_s, {6'd0, s_mem_addr}, s_done, s_err, s_cpu_hold);
  endtask

  vec_t vecs[5];
  bq_t  img;
  bq_t  basic;
  int   cnt;

  initial begin
    vecs[0] = '{stream: 80'h02_00_13_05_50_00_93_05_A0_00, nbytes: 4'd10, gaps: 1'b0,
                exp_nwr: 8'd2, exp_addr: 8'd2, exp_w0: 32'h00500513, exp_w1: 32'h00A00593};
    vecs[1] = '{stream: 80'h00_00_00_00_00_00_00_00_00_00, nbytes: 4'd2, gaps: 1'b0,
                exp_nwr: 8'd0, exp_addr: 8'd0, exp_w0: 32'h0, exp_w1: 32'h0};
    vecs[2] = '{stream: 80'h01_00_EF_BE_AD_DE_00_00_00_00, nbytes: 4'd6, gaps: 1'b0,
                exp_nwr: 8'd1, exp_addr: 8'd1, exp_w0: 32'hDEADBEEF, exp_w1: 32'h0};
    vecs[3] = '{stream: 80'h02_00_01_02_03_04_FF_00_00_80, nbytes: 4'd10, gaps: 1'b1,
                exp_nwr: 8'd2, exp_addr: 8'd2, exp_w0: 32'h04030201, exp_w1: 32'h800000FF};
    vecs[4] = '{stream: 80'h02_00_13_05_50_00_93_05_A0_00, nbytes: 4'd10, gaps: 1'b1,
                exp_nwr: 8'd2, exp_addr: 8'd2, exp_w0: 32'h00500513, exp_w1: 32'h00A00593};

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_ready", 32'(s_in_ready), 32'd0);
    check("rst_s_hold", 32'(s_cpu_hold), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // Bytes offered while idle must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_nwr", wq.size(), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Directed image table.
    for (int v = 0; v < 5; v++) begin
      img = {};
      for (int i = 0; i < int'(vecs[v].nbytes); i++) img.push_back(vecs[v].stream[79-8*i -: 8]);
      run_load($sformatf("vec%0d", v), img, vecs[v].gaps, 1'b0, -1);
      check($sformatf("vec%0d_nwr", v), wq.size(), 32'(vecs[v].exp_nwr));
      check($sformatf("vec%0d_addr", v), 32'(mem_addr), 32'(vecs[v].exp_addr));
      check($sformatf("vec%0d_err", v), 32'(err), 32'd0);
      check($sformatf("vec%0d_hold", v), 32'(cpu_hold), 32'd0);
      if (wq.size() > 0) check($sformatf("vec%0d_w0", v), wq[0].data, vecs[v].exp_w0);
      if (wq.size() > 1) check($sformatf("vec%0d_w1", v), wq[1].data, vecs[v].exp_w1);
    end

    // Write timing: strobe the cycle after the 4th byte, address bumps the cycle after.
    wq.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t_we0", 32'(mem_we), 32'd1);
    check("t_addr0", 32'(mem_addr), 32'd0);
    check("t_wdata0", mem_wdata, 32'h00500513);
    check("t_ready_in_write", 32'(in_ready), 32'd1);
    send_byte(8'h93, 1'b0);
    check("t_we_pulse", 32'(mem_we), 32'd0);
    check("t_addr_inc", 32'(mem_addr), 32'd1);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t_we1", 32'(mem_we), 32'd1);
    check("t_addr1", 32'(mem_addr), 32'd1);
    check("t_wdata1", mem_wdata, 32'h00A00593);
    tick();
    check("t_we_end", 32'(mem_we), 32'd0);
    check("t_addr_end", 32'(mem_addr), 32'd2);
    if (CsumEn) send_byte(8'h70, 1'b0);
    wait_done("t");
    check("t_hold", 32'(cpu_hold), 32'd0);
    check("t_nwr", wq.size(), 32'd2);

    // Bytes offered in DONE are ignored too.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    check("done_ready", 32'(in_ready), 32'd0);
    check("done_nwr", wq.size(), 32'd2);
    check("done_level", 32'(done), 32'd1);
    check("done_addr", 32'(mem_addr), 32'd2);

    // Overflow on the 4-word instance: five words, fifth dropped.
    img = {};
    img.push_back(8'h05);
    img.push_back(8'h00);
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    run_load("ovf", img, 1'b0, 1'b0, -1);
    check("ovf_s_nwr", wq_s.size(), 32'd4);
    check("ovf_s_err", 32'(s_err), 32'd1);
    check("ovf_s_done", 32'(s_done), 32'd1);
    check("ovf_s_addr", 32'(s_mem_addr), 32'd3);
    check("ovf_s_hold", 32'(s_cpu_hold), CsumEn ? 32'd1 : 32'd0);
    check("ovf_m_nwr", wq.size(), 32'd5);
    check("ovf_m_err", 32'(err), 32'd0);

    // Bad checksum byte (has no effect without the checksum option).
    basic = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    run_load("badcs", basic, 1'b0, 1'b1, -1);
    check("badcs_err", 32'(err), CsumEn ? 32'd1 : 32'd0);

    // Random images, gaps, stray start pulses mid-load.
    for (int it = 0; it < 20; it++) begin
      cnt = $urandom_range(0, 6);
      img = {};
      img.push_back(8'(cnt));
      img.push_back(8'h00);
      for (int i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", it), img, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 14)) - 2);
    end

    // Reset mid-DATA: one full word written, partial second word must vanish.
    wq.delete();
    wq_s.delete();
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h11 * i), 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_hold", 32'(cpu_hold), 32'd1);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h88;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("arst_nwr", wq.size(), 32'd1);
    if (wq.size() > 0) check("arst_w0", wq[0].data, 32'h44332211);
    check("arst_hold_after", 32'(cpu_hold), 32'd1);
    check("arst_s_hold", 32'(s_cpu_hold), 32'd1);
    check("arst_done_after", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
